// File: rtl/freq_meter.sv
// freq_meter: counts synchronized rising edges of sig_in over a fixed
// window of GATE_CYCLES clk cycles and reports the count once per window.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 100000000,
  parameter int unsigned CNT_W       = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             en,
  output logic [CNT_W-1:0] freq,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned         GATE_W    = $clog2(GATE_CYCLES);
  localparam int unsigned         SUM_W     = CNT_W + 1;
  localparam logic [GATE_W-1:0]   GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_t;

  state_t              state_q;
  logic                s1_q;
  logic                s2_q;
  logic                s3_q;
  logic [GATE_W-1:0]   gate_cnt_q;
  logic [CNT_W-1:0]    edge_cnt_q;
  logic [CNT_W-1:0]    edge_cnt_d;
  logic                sat_q;
  logic                sat_d;
  logic [CNT_W-1:0]    freq_q;
  logic                valid_q;
  logic                overflow_q;
  logic                rise_c;
  logic [SUM_W-1:0]    sum_c;
  logic                add_sat_c;

  // Two-flop synchronizer plus history flop; runs in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_c = s2_q & ~s3_q;

  // Saturating edge-count increment, shared by counting and terminal cycles.
  always_comb begin
    sum_c      = {1'b0, edge_cnt_q} + SUM_W'(rise_c);
    add_sat_c  = sum_c[SUM_W-1];
    edge_cnt_d = add_sat_c ? CNT_MAX : sum_c[CNT_W-1:0];
    sat_d      = sat_q | add_sat_c;
  end

  // Gate FSM: window counting, result capture, abort on en low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      freq_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (state_q == IDLE) begin
        if (en) begin
          state_q    <= GATE;
          gate_cnt_q <= '0;
          edge_cnt_q <= '0;
          sat_q      <= 1'b0;
        end
      end else begin
        if (!en) begin
          // Abort: partial window is dropped, results keep their old values.
          state_q    <= IDLE;
          gate_cnt_q <= '0;
          edge_cnt_q <= '0;
          sat_q      <= 1'b0;
        end else if (gate_cnt_q == GATE_LAST) begin
          // Terminal cycle: its own rise belongs to the ending window.
          freq_q     <= edge_cnt_d;
          overflow_q <= sat_d;
          valid_q    <= 1'b1;
          gate_cnt_q <= '0;
          edge_cnt_q <= '0;
          sat_q      <= 1'b0;
        end else begin
          gate_cnt_q <= gate_cnt_q + GATE_W'(1);
          edge_cnt_q <= edge_cnt_d;
          sat_q      <= sat_d;
        end
      end
    end
  end

  assign freq     = freq_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;
  assign busy     = (state_q == GATE);

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (CNT_W=8 and CNT_W=5) share stimulus and
// are compared against a window-sum reference model each cycle.
module tb_freq_meter;

  localparam int GC   = 100;
  localparam int HIST = 16384;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sig_in = 1'b0;
  logic       en = 1'b0;
  logic [7:0] freq8;
  logic       valid8, ovf8, busy8;
  logic [4:0] freq5;
  logic       valid5, ovf5, busy5;

  freq_meter #(.GATE_CYCLES(GC), .CNT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .sig_in(sig_in), .en(en),
    .freq(freq8), .valid(valid8), .overflow(ovf8), .busy(busy8)
  );

  freq_meter #(.GATE_CYCLES(GC), .CNT_W(5)) u_dut5 (
    .clk(clk), .rst(rst), .sig_in(sig_in), .en(en),
    .freq(freq5), .valid(valid5), .overflow(ovf5), .busy(busy5)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: sampled sig_in history, derived rises, window bookkeeping.
  int   k = 0;
  int   base = 1;
  int   p = 0;
  bit   in_gate = 1'b0;
  bit   xh [HIST];
  bit   rh [HIST];
  int   last_sum;
  logic       exp_valid = 1'b0;
  logic       exp_busy  = 1'b0;
  logic       exp_ov8   = 1'b0;
  logic       exp_ov5   = 1'b0;
  logic [7:0] exp_f8    = '0;
  logic [4:0] exp_f5    = '0;

  logic [18:0] obs_w;
  logic [18:0] exp_w;
  assign obs_w = {valid8, busy8, ovf8, freq8, valid5, busy5, ovf5, freq5};
  assign exp_w = {exp_valid, exp_busy, exp_ov8, exp_f8, exp_valid, exp_busy, exp_ov5, exp_f5};

  function automatic bit x_at(int i);
    return (i >= base) ? xh[i] : 1'b0;
  endfunction

  task automatic reset_model();
    in_gate   = 1'b0;
    exp_valid = 1'b0;
    exp_busy  = 1'b0;
    exp_ov8   = 1'b0;
    exp_ov5   = 1'b0;
    exp_f8    = '0;
    exp_f5    = '0;
    base      = k + 1;
  endtask

  // One clk cycle: drive on negedge, advance model at posedge, settle 1 time unit.
  task automatic step(input bit s, input bit e);
    @(negedge clk);
    sig_in = s;
    en     = e;
    @(posedge clk);
    k++;
    if (k >= HIST) begin
      $display("FAIL history_limit k=%0d limit=%0d", k, HIST);
      $fatal(1);
    end
    xh[k]     = s;
    rh[k]     = x_at(k - 1) & ~x_at(k - 2);
    exp_valid = 1'b0;
    if (!in_gate) begin
      if (e) begin
        in_gate = 1'b1;
        p       = k;
      end
    end else if (!e) begin
      in_gate = 1'b0;
    end else if (k - 1 - p == GC - 1) begin
      last_sum = 0;
      for (int i = p; i < p + GC; i++) last_sum += int'(rh[i]);
      exp_valid = 1'b1;
      exp_f8    = (last_sum > 255) ? 8'd255 : 8'(last_sum);
      exp_ov8   = (last_sum > 255);
      exp_f5    = (last_sum > 31) ? 5'd31 : 5'(last_sum);
      exp_ov5   = (last_sum > 31);
      p         = k;
    end
    exp_busy = in_gate;
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    reset_model();
    #2;
    n_vec++;
    if (obs_w !== 19'd0) begin
      n_err++;
      $display("FAIL reset_state got=%h want=%h", obs_w, 19'd0);
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 30; i++) begin
      step(i[1], 1'b0);
      n_vec++;
      if (obs_w !== exp_w) begin
        n_err++;
        $display("FAIL idle k=%0d got=%h want=%h", k, obs_w, exp_w);
      end
    end
  endtask

  task automatic test_square();
    int nvalid = 0;
    int last_k = -1;
    for (int i = 0; i < 320; i++) begin
      step((i % 10) < 5, 1'b1);
      n_vec++;
      if (obs_w !== exp_w) begin
        n_err++;
        $display("FAIL square k=%0d got=%h want=%h", k, obs_w, exp_w);
      end
      if (valid8 === 1'b1) begin
        nvalid++;
        n_vec++;
        if (freq8 !== 8'd10 || ovf8 !== 1'b0 || freq5 !== 5'd10 || ovf5 !== 1'b0) begin
          n_err++;
          $display("FAIL square_freq got=%0d/%0d want=10/10", freq8, freq5);
        end
        if (last_k >= 0) begin
          n_vec++;
          if (k - last_k !== GC) begin
            n_err++;
            $display("FAIL square_spacing got=%0d want=%0d", k - last_k, GC);
          end
        end
        last_k = k;
      end
    end
    n_vec++;
    if (nvalid !== 3) begin
      n_err++;
      $display("FAIL square_count got=%0d want=3", nvalid);
    end
  endtask

  task automatic test_max_rate();
    int nvalid = 0;
    for (int i = 0; i < 320; i++) begin
      step(i[0], 1'b1);
      n_vec++;
      if (obs_w !== exp_w) begin
        n_err++;
        $display("FAIL max_rate k=%0d got=%h want=%h", k, obs_w, exp_w);
      end
      if (valid8 === 1'b1) begin
        nvalid++;
        if (nvalid > 1) begin
          n_vec++;
          if (freq8 !== 8'd50 || ovf8 !== 1'b0 || freq5 !== 5'd31 || ovf5 !== 1'b1) begin
            n_err++;
            $display("FAIL max_rate_freq got=%0d/%0d ovf=%b/%b want=50/31 ovf=0/1",
                     freq8, freq5, ovf8, ovf5);
          end
        end
      end
    end
  endtask

  task automatic test_const();
    for (int ph = 0; ph < 2; ph++) begin
      int nvalid = 0;
      for (int i = 0; i < 350; i++) begin
        step(ph == 0, 1'b1);
        n_vec++;
        if (obs_w !== exp_w) begin
          n_err++;
          $display("FAIL const k=%0d got=%h want=%h", k, obs_w, exp_w);
        end
        if (valid8 === 1'b1) begin
          nvalid++;
          if (nvalid > 1) begin
            n_vec++;
            if (freq8 !== 8'd0 || freq5 !== 5'd0 || ovf8 !== 1'b0) begin
              n_err++;
              $display("FAIL const_freq got=%0d/%0d want=0/0", freq8, freq5);
            end
          end
        end
      end
    end
  endtask

  task automatic test_abort();
    bit         got = 1'b0;
    logic [7:0] held8;
    int         p_enter;
    int         i;
    // sync to a window boundary so gate_cnt is known
    for (i = 0; i < 150 && !got; i++) begin
      step(i[1], 1'b1);
      got = exp_valid;
    end
    while (k - p < 50) step(k[1], 1'b1);
    held8 = exp_f8;
    for (i = 0; i < 6; i++) begin
      step(k[1], 1'b0);
      n_vec++;
      if (obs_w !== exp_w || valid8 !== 1'b0 || freq8 !== held8) begin
        n_err++;
        $display("FAIL abort_hold k=%0d got=%h want=%h", k, obs_w, exp_w);
      end
    end
    step(k[1], 1'b1);
    p_enter = k;
    got = 1'b0;
    for (i = 0; i < 150 && !got; i++) begin
      step(k[1], 1'b1);
      n_vec++;
      if (obs_w !== exp_w) begin
        n_err++;
        $display("FAIL abort_resume k=%0d got=%h want=%h", k, obs_w, exp_w);
      end
      got = (valid8 === 1'b1);
    end
    n_vec++;
    if (!got || k - p_enter !== GC) begin
      n_err++;
      $display("FAIL abort_latency got=%0d want=%0d", got ? k - p_enter : -1, GC);
    end
  endtask

  task automatic test_terminal_rise();
    int p0;
    int nvalid = 0;
    repeat (4) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    p0 = k;
    for (int i = 0; i < 250 && nvalid < 2; i++) begin
      step((k + 1) >= p0 + GC - 2, 1'b1);
      n_vec++;
      if (obs_w !== exp_w) begin
        n_err++;
        $display("FAIL terminal k=%0d got=%h want=%h", k, obs_w, exp_w);
      end
      if (valid8 === 1'b1) begin
        nvalid++;
        n_vec++;
        if (freq8 !== ((nvalid == 1) ? 8'd1 : 8'd0)) begin
          n_err++;
          $display("FAIL terminal_freq window=%0d got=%0d want=%0d",
                   nvalid, freq8, (nvalid == 1) ? 1 : 0);
        end
      end
    end
    n_vec++;
    if (nvalid !== 2) begin
      n_err++;
      $display("FAIL terminal_count got=%0d want=2", nvalid);
    end
  endtask

  task automatic test_reset_mid();
    bit got = 1'b0;
    int n   = 0;
    for (int i = 0; i < 250 && !(in_gate && k - p == 70); i++) step((k % 6) < 3, 1'b1);
    #3 rst = 1'b1;
    reset_model();
    #1;
    n_vec++;
    if (obs_w !== 19'd0) begin
      n_err++;
      $display("FAIL reset_mid_now got=%h want=%h", obs_w, 19'd0);
    end
    repeat (2) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (obs_w !== 19'd0) begin
        n_err++;
        $display("FAIL reset_mid_hold got=%h want=%h", obs_w, 19'd0);
      end
    end
    @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 150 && !got; i++) begin
      step((k % 6) < 3, 1'b1);
      n++;
      n_vec++;
      if (obs_w !== exp_w) begin
        n_err++;
        $display("FAIL reset_mid_run k=%0d got=%h want=%h", k, obs_w, exp_w);
      end
      got = (valid8 === 1'b1);
    end
    n_vec++;
    if (!got || n !== GC + 1) begin
      n_err++;
      $display("FAIL reset_mid_latency got=%0d want=%0d", got ? n : -1, GC + 1);
    end
  endtask

  task automatic test_rst_sig_high();
    bit got = 1'b0;
    @(negedge clk);
    sig_in = 1'b1;
    en     = 1'b1;
    #2 rst = 1'b1;
    reset_model();
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 150 && !got; i++) begin
      step(1'b1, 1'b1);
      n_vec++;
      if (obs_w !== exp_w) begin
        n_err++;
        $display("FAIL rst_sig_high k=%0d got=%h want=%h", k, obs_w, exp_w);
      end
      got = (valid8 === 1'b1);
    end
    n_vec++;
    if (!got || freq8 !== 8'd1) begin
      n_err++;
      $display("FAIL rst_sig_high_freq got=%0d want=1", got ? int'(freq8) : -1);
    end
  endtask

  task automatic test_random();
    bit s = 1'b0;
    bit e = 1'b1;
    int hold = 0;
    int off = 0;
    for (int i = 0; i < 2500; i++) begin
      if (hold == 0) begin
        s    = ~s;
        hold = ((i / 500) % 2 == 1) ? $urandom_range(1, 2) : $urandom_range(1, 12);
      end
      hold--;
      if (off > 0) begin
        off--;
        e = 1'b0;
      end else begin
        e = 1'b1;
        if ($urandom_range(0, 299) == 0) off = $urandom_range(1, 6);
      end
      step(s, e);
      n_vec++;
      if (obs_w !== exp_w) begin
        n_err++;
        $display("FAIL random k=%0d got=%h want=%h", k, obs_w, exp_w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_square();
    test_max_rate();
    test_const();
    test_abort();
    test_terminal_rise();
    test_reset_mid();
    test_rst_sig_high();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter GATE_CYCLES, default 100000000, is the measurement window length in clk cycles (1 s at 100 MHz); legal range is >= 2.
REQ-002 Parameter CNT_W, default 27, is the width of the edge count and of the freq result.
REQ-003 Port clk  input  1  system clock; all state is on the rising edge.
REQ-004 Port rst  input  1  reset: asynchronous, active-high.
REQ-005 Port sig_in  input  1  signal under measurement; asynchronous to clk.
REQ-006 Port en  input  1  measurement enable; level-sensitive.
REQ-007 Port freq  output  CNT_W  rising-edge count of the last completed window.
REQ-008 Port valid  output  1  one-cycle pulse when freq and overflow update.
REQ-009 Port overflow  output  1  last completed window saturated the edge count.
REQ-010 Port busy  output  1  high while in state GATE.

Function
REQ-011 sig_in SHALL pass through a two-flop synchronizer (s1, s2) followed by a history flop s3.
- rise = s2 & ~s3.
- The synchronizer and history flop run in every state.
REQ-012 Latency from a sig_in rising edge to rise asserted SHALL be 2 to 3 clk cycles.
REQ-013 The FSM SHALL have two states: IDLE and GATE.
REQ-014 IDLE with en=1 SHALL go to GATE on the next edge, with gate_cnt=0 and edge_cnt=0.
REQ-015 IDLE with en=0 SHALL stay in IDLE.
REQ-016 In GATE, gate_cnt SHALL increment by 1 per cycle; it is ceil(log2(GATE_CYCLES)) bits wide.
REQ-017 The measurement window SHALL be the GATE_CYCLES cycles with gate_cnt = 0 .. GATE_CYCLES-1 inclusive.
REQ-018 In GATE, edge_cnt SHALL increment on each cycle with rise=1.
- edge_cnt saturates at 2^CNT_W-1 (no wrap).
- Saturation sets an internal sat flag.
REQ-019 Terminal cycle (gate_cnt==GATE_CYCLES-1 and en=1), on the next edge:
- freq <= edge_cnt + rise, saturated to 2^CNT_W-1.
- overflow <= sat, or 1 if the add saturated.
- valid <= 1 for exactly one cycle.
- gate_cnt, edge_cnt and sat <= 0; state stays GATE.
REQ-020 Back-to-back windows SHALL have no dead cycles; a rise in the terminal cycle counts in the ending window only.
REQ-021 en=0 in any GATE cycle, including the terminal cycle, SHALL abort:
- next state IDLE; gate_cnt, edge_cnt and sat cleared.
- no valid; freq and overflow retain their previous values.
REQ-022 en=1 after an abort SHALL start a fresh full window per REQ-014; partial counts are never reported.
REQ-023 Rises while in IDLE SHALL NOT be counted.
REQ-024 freq and overflow SHALL hold their values between valid pulses.
REQ-025 valid SHALL be 0 in every cycle except the one following a terminal cycle.
REQ-026 busy SHALL be 1 exactly when state==GATE.

Reset
REQ-027 rst=1 SHALL immediately force the following, regardless of clk:
- state IDLE;
- gate_cnt, edge_cnt, sat = 0;
- s1, s2, s3 = 0;
- freq = 0, valid = 0, overflow = 0, busy = 0.
REQ-028 rst asserted mid-window SHALL discard the window with no valid.
- After release, operation resumes per REQ-014.
REQ-029 If sig_in is high at rst release, the resulting single rise SHALL count as one edge if it falls in a GATE cycle.

Verification (GATE_CYCLES=100, CNT_W=8 unless stated)
REQ-030 en=1 continuously, sig_in square wave period 10 clk -> valid every 100 cycles, freq=10, overflow=0.
REQ-031 sig_in period 2 clk (max rate) -> freq=50; second configuration with CNT_W=5 -> freq=31, overflow=1.
REQ-032 en dropped at gate_cnt=50, then restored -> no valid during the abort, freq keeps its prior value, next valid is 100 cycles after re-entering GATE.
REQ-033 Single sig_in rise timed so rise=1 at gate_cnt=99 -> counted in that window (freq=1) and not in the following window (freq=0).
REQ-034 rst pulse at gate_cnt=70 -> all outputs 0 immediately, no valid; with en held high, first valid 101 cycles after rst release.
REQ-035 sig_in held constant high or low for 3 windows -> freq=0 each window, valid every 100 cycles.
